// File: rtl/phase_pkg.sv
// Shared definitions for the instruction-phase sequencer.
//   state_t   : sequencer control states (IDLE, RUN, STEP)
//   PH_*      : one-hot phase encodings {WB,EX,DE,FE}, PH_NONE when idle
//   next_phase: rotation FE->DE->EX->WB->FE
package phase_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [3:0] PH_NONE = 4'b0000;
    localparam logic [3:0] PH_FE   = 4'b0001;
    localparam logic [3:0] PH_DE   = 4'b0010;
    localparam logic [3:0] PH_EX   = 4'b0100;
    localparam logic [3:0] PH_WB   = 4'b1000;

    // Rotate left by one; WB wraps back to FE.
    function automatic logic [3:0] next_phase(input logic [3:0] ph);
        return {ph[2:0], ph[3]};
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the sequencer and its controller.
//   run_i        : level, continuous execution request
//   step_i       : pulse, single-instruction request
//   div_i        : clocks per phase minus 1
//   phase_o      : one-hot {WB,EX,DE,FE}, zero in IDLE
//   phase_last_o : final clock of current phase
//   instr_done_o : final clock of WB
//   instr_cnt_o  : retired instruction count (wraps)
//   busy_o       : sequencer in RUN or STEP
// master: controller side, slave: sequencer side.
interface phase_sequencer_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
);
    logic             run_i;
    logic             step_i;
    logic [DIV_W-1:0] div_i;
    logic [3:0]       phase_o;
    logic             phase_last_o;
    logic             instr_done_o;
    logic [CNT_W-1:0] instr_cnt_o;
    logic             busy_o;

    modport master (
        output run_i, step_i, div_i,
        input  phase_o, phase_last_o, instr_done_o, instr_cnt_o, busy_o
    );

    modport slave (
        input  run_i, step_i, div_i,
        output phase_o, phase_last_o, instr_done_o, instr_cnt_o, busy_o
    );
endinterface

// File: rtl/phase_prescaler.sv
// Clock-per-phase prescaler.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : latch div_i into div_q and restart the count
//   en         : counting enabled (sequencer not idle); counter held at 0 otherwise
//   div_i      : clocks per phase minus 1
//   tick       : high on the final clock of a phase (pre == div_q while enabled)
module phase_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick
);

    logic [DIV_W-1:0] pre;
    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre   <= '0;
            div_q <= '0;
        end else if (load) begin
            div_q <= div_i;
            pre   <= '0;
        end else if (!en) begin
            pre   <= '0;
        end else if (pre == div_q) begin
            pre   <= '0;
        end else begin
            pre   <= pre + 1'b1;
        end
    end

    assign tick = en && (pre == div_q);

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer: turns the system clock into one-hot
// FETCH/DECODE/EXECUTE/WRITEBACK phase enables with a programmable
// prescaler, run/single-step control and a retired-instruction counter.
//   clk   : system clock (rising edge)
//   rst_n : synchronous active-low reset
//   bus   : phase_sequencer_if slave (run/step/div in, phase/status out)
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    phase_sequencer_if.slave  bus
);

    state_t           state;
    logic [3:0]       phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick;
    logic             active;
    logic             done;
    logic             load;

    assign active = (state != IDLE);
    assign done   = tick && (phase_q == PH_WB);

    // div_i is captured only when an instruction starts: leaving IDLE,
    // or at a RUN instruction boundary where execution continues.
    always_comb begin
        load = 1'b0;
        unique case (state)
            IDLE:    load = bus.run_i || bus.step_i;
            RUN:     load = done && bus.run_i;
            default: load = 1'b0;
        endcase
    end

    phase_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .en    (active),
        .div_i (bus.div_i),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            phase_q <= PH_NONE;
            cnt_q   <= '0;
        end else begin
            if (done) begin
                cnt_q <= cnt_q + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (bus.run_i) begin
                        state   <= RUN;
                        phase_q <= PH_FE;
                    end else if (bus.step_i) begin
                        state   <= STEP;
                        phase_q <= PH_FE;
                    end else begin
                        phase_q <= PH_NONE;
                    end
                end
                RUN: begin
                    if (done && !bus.run_i) begin
                        state   <= IDLE;
                        phase_q <= PH_NONE;
                    end else if (tick) begin
                        phase_q <= next_phase(phase_q);
                    end
                end
                STEP: begin
                    if (done) begin
                        state   <= IDLE;
                        phase_q <= PH_NONE;
                    end else if (tick) begin
                        phase_q <= next_phase(phase_q);
                    end
                end
                default: begin
                    state   <= IDLE;
                    phase_q <= PH_NONE;
                end
            endcase
        end
    end

    assign bus.phase_o      = phase_q;
    assign bus.phase_last_o = tick;
    assign bus.instr_done_o = done;
    assign bus.instr_cnt_o  = cnt_q;
    assign bus.busy_o       = active;

endmodule
